// File: rtl/seven_seg_io_pkg.sv
// Shared constants for the memory-mapped display and switch I/O block.
//   - Default I/O addresses (exact 32-bit match)
//   - Register and port widths
//   - HEX register reset pattern, which shows "FEDEAD" on the six digits
package seven_seg_io_pkg;

   localparam int unsigned DataBits  = 32;
   localparam int unsigned HexBits   = 24;
   localparam int unsigned LedrBits  = 10;
   localparam int unsigned KeyBits   = 4;
   localparam int unsigned SwBits    = 10;
   localparam int unsigned NumDigits = 6;

   localparam logic [31:0] AddrHex  = 32'hFFFFF000;
   localparam logic [31:0] AddrLedr = 32'hFFFFF020;
   localparam logic [31:0] AddrKey  = 32'hFFFFF080;
   localparam logic [31:0] AddrSw   = 32'hFFFFF090;

   localparam logic [23:0] HexResetVal = 24'hFEDEAD;

   // All segments off, active-low.
   localparam logic [6:0] SegBlank = 7'h7F;

endpackage

// File: rtl/hex_digit_decoder.sv
// Hex nibble to seven-segment decoder, purely combinational.
// Ports:
//   IN  [3:0] : nibble to display
//   OFF       : 1 blanks the digit (all segments off)
//   OUT [6:0] : segments {g,f,e,d,c,b,a}, active-low
module hex_digit_decoder
   import seven_seg_io_pkg::*;
(
   input  logic [3:0] IN,
   input  logic       OFF,
   output logic [6:0] OUT
);

   always_comb begin
      OUT = SegBlank;
      if (!OFF) begin
         case (IN)
            4'h0:    OUT = 7'h40;
            4'h1:    OUT = 7'h79;
            4'h2:    OUT = 7'h24;
            4'h3:    OUT = 7'h30;
            4'h4:    OUT = 7'h19;
            4'h5:    OUT = 7'h12;
            4'h6:    OUT = 7'h02;
            4'h7:    OUT = 7'h78;
            4'h8:    OUT = 7'h00;
            4'h9:    OUT = 7'h10;
            4'hA:    OUT = 7'h08;
            4'hB:    OUT = 7'h03;
            4'hC:    OUT = 7'h46;
            4'hD:    OUT = 7'h21;
            4'hE:    OUT = 7'h06;
            default: OUT = 7'h0E;
         endcase
      end
   end

endmodule

// File: rtl/seven_seg_io.sv
// Memory-mapped display and switch I/O for the processor MEM stage.
// Holds the HEX display register and LEDR register (written by stores) and
// returns KEY/SW/HEX/LEDR values on loads to the I/O addresses.
// Ports:
//   clk, reset       : PLL output clock, synchronous active-high reset
//   addr, wr_en      : MEM-stage address and store strobe
//   wdata            : store data
//   rdata            : combinational read data for addr (0 if not an I/O address)
//   io_hit           : addr matches one of the four I/O addresses
//   KEY, SW          : pushbuttons (active-low) and slide switches, unsynchronized
//   HEX0..HEX5       : active-low seven-segment digits, HEX5 most significant
//   LEDR             : red LEDs
module seven_seg_io
   import seven_seg_io_pkg::*;
#(
   parameter int unsigned          DBITS    = DataBits,
   parameter logic [DBITS-1:0]     ADDRHEX  = AddrHex,
   parameter logic [DBITS-1:0]     ADDRLEDR = AddrLedr,
   parameter logic [DBITS-1:0]     ADDRKEY  = AddrKey,
   parameter logic [DBITS-1:0]     ADDRSW   = AddrSw,
   parameter int unsigned          HEXBITS  = HexBits,
   parameter int unsigned          LEDRBITS = LedrBits,
   parameter int unsigned          KEYBITS  = KeyBits
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DBITS-1:0]    addr,
   input  logic                wr_en,
   input  logic [DBITS-1:0]    wdata,
   output logic [DBITS-1:0]    rdata,
   output logic                io_hit,
   input  logic [KEYBITS-1:0]  KEY,
   input  logic [SwBits-1:0]   SW,
   output logic [6:0]          HEX0,
   output logic [6:0]          HEX1,
   output logic [6:0]          HEX2,
   output logic [6:0]          HEX3,
   output logic [6:0]          HEX4,
   output logic [6:0]          HEX5,
   output logic [LEDRBITS-1:0] LEDR
);

   logic hit_hex, hit_ledr, hit_key, hit_sw;

   assign hit_hex  = (addr == ADDRHEX);
   assign hit_ledr = (addr == ADDRLEDR);
   assign hit_key  = (addr == ADDRKEY);
   assign hit_sw   = (addr == ADDRSW);
   assign io_hit   = hit_hex | hit_ledr | hit_key | hit_sw;

   logic [HEXBITS-1:0]  hex_q, hex_d;
   logic [LEDRBITS-1:0] ledr_q, ledr_d;

   always_comb begin
      hex_d  = hex_q;
      ledr_d = ledr_q;
      if (wr_en && hit_hex)  hex_d  = wdata[HEXBITS-1:0];
      if (wr_en && hit_ledr) ledr_d = wdata[LEDRBITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hex_q  <= HEXBITS'(HexResetVal);
         ledr_q <= '0;
      end else begin
         hex_q  <= hex_d;
         ledr_q <= ledr_d;
      end
   end

   // Reads see the registers before this cycle's store lands (no write-through).
   always_comb begin
      rdata = '0;
      if (hit_key) begin
         rdata[KEYBITS-1:0] = ~KEY;  // pressed key reads as 1
      end else if (hit_sw) begin
         rdata[SwBits-1:0] = SW;
      end else if (hit_hex) begin
         rdata[HEXBITS-1:0] = hex_q;
      end else if (hit_ledr) begin
         rdata[LEDRBITS-1:0] = ledr_q;
      end
   end

   assign LEDR = ledr_q;

   logic [6:0] seg [NumDigits];

   for (genvar i = 0; i < NumDigits; i++) begin : g_digit
      hex_digit_decoder u_digit (
         .IN  (hex_q[4*i +: 4]),
         .OFF (1'b0),
         .OUT (seg[i])
      );
   end

   assign HEX0 = seg[0];
   assign HEX1 = seg[1];
   assign HEX2 = seg[2];
   assign HEX3 = seg[3];
   assign HEX4 = seg[4];
   assign HEX5 = seg[5];

   // Store data above the HEX register width is never stored.
   logic unused_wdata;
   assign unused_wdata = ^wdata[DBITS-1:HEXBITS];

endmodule

// File: tb/tb_seven_seg_io.sv
module tb_seven_seg_io;
   import seven_seg_io_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, rdata;
   logic        wr_en, io_hit;
   logic [3:0]  KEY;
   logic [9:0]  SW;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [9:0]  LEDR;

   seven_seg_io dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .wr_en  (wr_en),
      .wdata  (wdata),
      .rdata  (rdata),
      .io_hit (io_hit),
      .KEY    (KEY),
      .SW     (SW),
      .HEX0   (HEX0),
      .HEX1   (HEX1),
      .HEX2   (HEX2),
      .HEX3   (HEX3),
      .HEX4   (HEX4),
      .HEX5   (HEX5),
      .LEDR   (LEDR)
   );

   always #5 clk = ~clk;

   typedef enum int {SigRdata, SigIoHit, SigLedr, SigHex} sig_e;
   typedef struct {
      string       tag;
      sig_e        sig;
      logic [63:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [23:0] m_hex;
   logic [9:0]  m_ledr;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tbl[n];
   endfunction

   function automatic logic [63:0] hex_exp(input logic [23:0] v);
      logic [63:0] r = '0;
      for (int i = 0; i < 6; i++) r[7*i +: 7] = seg_of(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [63:0] observe(input sig_e s);
      case (s)
         SigRdata: return {32'b0, rdata};
         SigIoHit: return {63'b0, io_hit};
         SigLedr:  return {54'b0, LEDR};
         default:  return {22'b0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
      endcase
   endfunction

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      case (a)
         32'hFFFFF080: return {28'b0, ~KEY};
         32'hFFFFF090: return {22'b0, SW};
         32'hFFFFF000: return {8'b0, m_hex};
         32'hFFFFF020: return {22'b0, m_ledr};
         default:      return 32'b0;
      endcase
   endfunction

   task automatic push(input string tag, input sig_e sig, input logic [63:0] exp);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic push_state(input string tag);
      push({tag, "_hex"}, SigHex, hex_exp(m_hex));
      push({tag, "_ledr"}, SigLedr, {54'b0, m_ledr});
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, observe(e.sig), e.exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
      @(negedge clk);
      addr  = a;
      wdata = d;
      wr_en = we;
   endtask

   task automatic edge_drain();
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      reset = 1'b1;
      addr  = '0;
      wdata = '0;
      wr_en = 1'b0;
      KEY   = 4'hF;
      SW    = '0;

      // Reset: digits show F,E,D,E,A,D
      @(posedge clk);
      #1;
      m_hex  = 24'hFEDEAD;
      m_ledr = '0;
      push("reset_hex_lit", SigHex, {22'b0, 7'h0E, 7'h06, 7'h21, 7'h06, 7'h08, 7'h21});
      push_state("reset");
      drain();

      // HEX write; same-cycle read returns old value
      @(negedge clk);
      reset = 1'b0;
      drive(32'hFFFFF000, 32'h00123456, 1'b1);
      #1;
      push("hex_rd_old", SigRdata, {32'b0, 32'h00FEDEAD});
      push("hex_hit", SigIoHit, 64'd1);
      drain();
      m_hex = 24'h123456;
      push("hex_wr_lit", SigHex, {22'b0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
      push("hex_rd_new", SigRdata, {32'b0, 32'h00123456});
      edge_drain();

      // LEDR write, then write to unmapped neighbour
      drive(32'hFFFFF020, 32'hFFFFFFFF, 1'b1);
      m_ledr = 10'h3FF;
      push_state("ledr_wr");
      edge_drain();
      drive(32'hFFFFF024, 32'h00001234, 1'b1);
      #1;
      push("unmapped_hit", SigIoHit, 64'd0);
      push("unmapped_rd", SigRdata, 64'd0);
      drain();
      push_state("unmapped_wr");
      edge_drain();

      // KEY read, combinational
      drive(32'hFFFFF080, 32'h0, 1'b0);
      KEY = 4'b1010;
      #1;
      push("key_rd", SigRdata, {32'b0, 32'h00000005});
      push("key_hit", SigIoHit, 64'd1);
      drain();

      // SW read, then write to SW address changes nothing
      drive(32'hFFFFF090, 32'h0, 1'b0);
      SW = 10'h2A5;
      #1;
      push("sw_rd", SigRdata, {32'b0, 32'h000002A5});
      drain();
      drive(32'hFFFFF090, 32'h0000FFFF, 1'b1);
      push_state("sw_wr");
      edge_drain();
      drive(32'hFFFFF080, 32'h0000FFFF, 1'b1);
      push_state("key_wr");
      edge_drain();

      // Back-to-back HEX writes, last wins
      drive(32'hFFFFF000, 32'h00111111, 1'b1);
      m_hex = 24'h111111;
      push_state("b2b_1");
      edge_drain();
      drive(32'hFFFFF000, 32'hFF0F0F0F, 1'b1);
      m_hex = 24'h0F0F0F;
      push_state("b2b_2");
      push("b2b_rd", SigRdata, {32'b0, 32'h000F0F0F});
      edge_drain();

      // Random mix of stores and loads against the model
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, d;
         logic        we;
         case ($urandom_range(0, 4))
            0:       a = 32'hFFFFF000;
            1:       a = 32'hFFFFF020;
            2:       a = 32'hFFFFF090;
            3:       a = 32'hFFFFF080;
            default: a = 32'hFFFFF004;
         endcase
         d  = $urandom;
         we = 1'($urandom_range(0, 1));
         drive(a, d, we);
         KEY = 4'($urandom);
         SW  = 10'($urandom);
         #1;
         push($sformatf("rnd%0d_rd", i), SigRdata, {32'b0, rd_model(a)});
         drain();
         if (we && a == 32'hFFFFF000) m_hex  = d[23:0];
         if (we && a == 32'hFFFFF020) m_ledr = d[9:0];
         push_state($sformatf("rnd%0d", i));
         edge_drain();
      end

      // Reset wins over a simultaneous write
      drive(32'hFFFFF000, 32'h00ABCDEF, 1'b1);
      reset  = 1'b1;
      m_hex  = 24'hFEDEAD;
      m_ledr = '0;
      push_state("rst_prio");
      push("rst_prio_rd", SigRdata, {32'b0, 32'h00FEDEAD});
      edge_drain();

      @(negedge clk);
      wr_en = 1'b0;
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_io.md
# seven_seg_io

Memory-mapped display and switch I/O block for the pipelined processor's MEM stage. It holds the 24-bit HEX display register and the 10-bit LEDR register, both written by store instructions. It drives six active-low seven-segment digits, and it returns KEY and SW values on load instructions to I/O addresses. The PLL stays outside this block; the block runs on the PLL output clock.

## Interface
Parameters:
- DBITS, 32: data and address width
- ADDRHEX, 32'hFFFFF000: HEX register address
- ADDRLEDR, 32'hFFFFF020: LEDR register address
- ADDRKEY, 32'hFFFFF080: KEY input address (read-only)
- ADDRSW, 32'hFFFFF090: SW input address (read-only)
- HEXBITS, 24: HEX register width
- LEDRBITS, 10: LEDR width
- KEYBITS, 4: KEY width

Ports:
- clk, in, 1: the single clock, PLL output
- reset, in, 1: synchronous, active-high
- addr, in, DBITS: MEM-stage memory address
- wr_en, in, 1: store is in MEM this cycle
- wdata, in, DBITS: store data
- rdata, out, DBITS: read data for addr
- io_hit, out, 1: addr matches one of the four I/O addresses
- KEY, in, 4: pushbuttons, active-low
- SW, in, 10: slide switches
- HEX0..HEX5, out, 7 each: segments {g,f,e,d,c,b,a}, active-low
- LEDR, out, 10: red LEDs

## Operation
- Address decode is exact 32-bit compare. io_hit = (addr is ADDRHEX, ADDRLEDR, ADDRKEY or ADDRSW).
- Writes:
  - wr_en && addr==ADDRHEX: HEX_reg <= wdata[23:0].
  - wr_en && addr==ADDRLEDR: LEDR_reg <= wdata[9:0].
  - Writes to ADDRKEY, ADDRSW or any other address have no effect.
- Reads are combinational and independent of wr_en:
  - ADDRKEY: {28'b0, ~KEY}, so a pressed key reads as 1.
  - ADDRSW: {22'b0, SW}.
  - ADDRHEX: {8'b0, HEX_reg}.
  - ADDRLEDR: {22'b0, LEDR_reg}.
  - Any other address: 0.
- LEDR = LEDR_reg.
- HEXn shows the decode of nibble HEX_reg[4n+3:4n]; HEX5 is the most significant digit.
- Digit decode, 7-bit active-low, hex values listed for digits 0-F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- Blank input OFF=1 forces 7F (all segments off). OFF is tied to 0 for all six digits.

## Timing
- Reset is synchronous. At the first clk edge with reset=1: HEX_reg = 24'hFEDEAD, so HEX5..HEX0 show F,E,D,E,A,D, and LEDR_reg = 0.
- Reset takes priority over a simultaneous write.
- Write latency is one cycle. A register updates at the clk edge where wr_en is sampled. HEX and LEDR outputs reflect the new value right after that edge, because segment decode is combinational from the register.
- A read in the same cycle as a write to the same register returns the old value; there is no write-through.
- KEY and SW are not synchronized inside the block. rdata follows them combinationally, and the MEM-stage latch samples it.
- A write with wr_en asserted across consecutive cycles updates the register every cycle; the last write wins.

## Structure
- Shared package holds: I/O address constants, HEXBITS/LEDRBITS/KEYBITS, and the reset value 24'hFEDEAD.
- One sub-module, hex_digit_decoder: IN[3:0], OFF, OUT[6:0], purely combinational, instantiated six times.

## Test plan
- Reset: assert reset for one clk -> HEX5..HEX0 = 0E,06,21,06,08,21; LEDR = 0.
- HEX write: addr=FFFFF000, wdata=0x00123456, wr_en for 1 cycle -> next cycle HEX5..HEX0 = 79,24,30,19,12,02; reading FFFFF000 returns 0x00123456.
- LEDR write: wdata=0xFFFFFFFF to FFFFF020 -> LEDR=0x3FF. Then a write of 0x1234 to FFFFF024 -> LEDR unchanged, io_hit=0.
- KEY read: KEY=4'b1010 (keys 0 and 2 pressed), addr=FFFFF080 -> rdata=0x00000005, io_hit=1, with no clk edge needed.
- SW read: SW=10'h2A5, addr=FFFFF090 -> rdata=0x000002A5. A write of 0xFFFF to FFFFF090 -> no register changes.
- Reset mid-operation: write HEX=0xABCDEF and assert reset on the same edge -> HEX_reg=0xFEDEAD.
